// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, 8 lines x 16 B.
// Hits answer combinationally; misses stall and fill a whole block.
module icache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_e;

  state_e         state_q;
  logic [7:0]     valid_q;
  logic [2:0]     tag_q  [8];
  logic [127:0]   data_q [8];
  logic [5:0]     miss_q;

  logic [2:0]     pc_tag;
  logic [2:0]     pc_idx;
  logic [1:0]     pc_off;
  logic [127:0]   line;
  logic           hit;
  logic           unused_pc;

  assign pc_tag    = PC[9:7];
  assign pc_idx    = PC[6:4];
  assign pc_off    = PC[3:2];
  assign unused_pc = ^{PC[31:10], PC[1:0]};
  assign line      = data_q[pc_idx];

  // Lookup only counts in IDLE; other states are mid-refill.
  assign hit = (state_q == IDLE) && valid_q[pc_idx]
               && (tag_q[pc_idx] == pc_tag);

  // Controller and storage: detect miss, wait on memory, fill line.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      miss_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!hit) begin
            miss_q  <= PC[9:4];
            state_q <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            data_q[miss_q[2:0]]  <= mem_readdata;
            tag_q[miss_q[2:0]]   <= miss_q[5:3];
            valid_q[miss_q[2:0]] <= 1'b1;
            state_q              <= UPDATE;
          end
        end
        UPDATE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // CPU and memory side outputs; reset forces everything quiet.
  always_comb begin
    INSTRUCTION = '0;
    BUSYWAIT    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    if (!RESET) begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            INSTRUCTION = line[{pc_off, 5'b0} +: 32];
          end else begin
            BUSYWAIT = 1'b1;
          end
        end
        MEM_READ: begin
          BUSYWAIT    = 1'b1;
          mem_read    = 1'b1;
          mem_address = miss_q;
        end
        UPDATE: BUSYWAIT = 1'b1;
        default: BUSYWAIT = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the CPU fetch port (PC out, INSTRUCTION in) and the block-wide instruction memory. Hits return the instruction combinationally in the same cycle. Misses assert BUSYWAIT to stall the CPU, fetch a 16-byte block over a busy-wait handshake, fill the line, then serve the fetch. Capacity is 8 lines × 4 words (128 B), covering a 1 KB instruction space.

## Interface
- Parameters: none. Geometry is fixed at 8 lines, 128-bit lines, 10-bit byte address.
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- PC  in  32  fetch byte address from the CPU. Only PC[9:0] is used: tag = PC[9:7], index = PC[6:4], word offset = PC[3:2]. PC[1:0] and PC[31:10] are ignored.
- INSTRUCTION  out  32  fetched instruction. Valid only while BUSYWAIT = 0.
- BUSYWAIT  out  1  stall request to the CPU.
- mem_read  out  1  block read request to instruction memory.
- mem_address  out  6  block address = {tag, index} of the missing line.
- mem_readdata  in  128  block data. Word k occupies bits [32k+31:32k].
- mem_busywait  in  1  high while the memory read is in progress. Low for the cycle mem_readdata is valid.

## Operation
- Storage: valid[7:0]; tag[7:0] (3 b each); data[7:0] (128 b each).
- Lookup (combinational, IDLE only): hit = valid[index] && (tag[index] == PC[9:7]).
- FSM states: IDLE, MEM_READ, UPDATE. Reset state is IDLE.
- IDLE:
  - Hit: BUSYWAIT = 0; INSTRUCTION = data[index] word PC[3:2]; stay in IDLE.
  - Miss: BUSYWAIT = 1; INSTRUCTION = 0. Latch {PC[9:7], PC[6:4]} into miss_addr at the posedge, then go to MEM_READ.
- MEM_READ:
  - Outputs: mem_read = 1, mem_address = miss_addr, BUSYWAIT = 1.
  - Stay while mem_busywait = 1.
  - At the first posedge with mem_busywait = 0: write mem_readdata to data[miss_addr index], write miss_addr tag, set the valid bit, then go to UPDATE.
- UPDATE:
  - Outputs: mem_read = 0, BUSYWAIT = 1.
  - Unconditionally return to IDLE. IDLE re-evaluates the current PC.
- Outside MEM_READ: mem_read = 0 and mem_address = 0.
- Memory contract: memory raises mem_busywait combinationally in the first cycle mem_read is seen. The fill therefore cannot occur in the first MEM_READ cycle unless memory has zero latency.
- The CPU holds PC stable while BUSYWAIT = 1. If PC changes anyway, the fill still targets miss_addr, and IDLE looks up the new PC afterwards.
- There are no writes from the CPU and no dirty state. A fill overwrites the line unconditionally.

## Timing
- Hit latency: 0 cycles. INSTRUCTION and BUSYWAIT = 0 settle combinationally from PC.
- Miss penalty: 1 (IDLE detect) + N (MEM_READ cycles, where N = memory cycles until mem_busywait = 0, N ≥ 1) + 1 (UPDATE). The hit is served in the following IDLE cycle.
- Reset (posedge with RESET = 1):
  - valid = 0, state = IDLE, miss_addr = 0.
  - Tag and data arrays are not cleared.
- While RESET = 1, outputs are forced combinationally: BUSYWAIT = 0, mem_read = 0, mem_address = 0, INSTRUCTION = 0.
- Reset during MEM_READ: the read is abandoned and no fill occurs. mem_read is 0 from the reset cycle onward, and memory must tolerate the dropped request.
- First cycle after reset release: every access misses.
- Conflict (same index, different tag): the line is replaced. There is no write-back.
- Word offset 3 (PC[3:2] = 3) selects bits [127:96]. The index wraps at PC[6:4] = 7.

## Test plan
- Cold miss: reset, then PC = 0x000 with memory latency 5 and block {w3..w0} = {0x33,0x22,0x11,0x00000000}.
  - BUSYWAIT = 1 for exactly 7 cycles, mem_read = 1 for 5 cycles, mem_address = 0.
  - Then BUSYWAIT = 0 and INSTRUCTION = 0x00000000.
- Same-block hits: after the fill, step PC through 0x004, 0x008, 0x00C, one per cycle.
  - BUSYWAIT stays 0; INSTRUCTION = 0x11, 0x22, 0x33 in the same cycle; mem_read is never asserted.
- Conflict eviction: fill PC = 0x010 (index 1, tag 0), then access PC = 0x090 (index 1, tag 1).
  - Miss with mem_address = 6'b001001.
  - A subsequent access to 0x010 misses again with mem_address = 6'b000001.
- Reset mid-miss: assert RESET during the 3rd MEM_READ cycle.
  - mem_read and BUSYWAIT are 0 in that cycle; after release, PC = 0x000 misses again (valid cleared).
- Zero-latency memory: mem_busywait held at 0.
  - Miss penalty is exactly 3 cycles with mem_read high for 1 cycle.
- Last line/last word: PC = 0x3FC.
  - Miss with mem_address = 6'b111111; INSTRUCTION = mem_readdata[127:96] after the fill. PC = 0x7FC aliases to the same line and hits.
